bch_enc_ctrl: RTL
=================

Name: bch_enc_ctrl

Overview:
Sequencing controller for the serial BCH(15,7) encode path.
- Accepts K message bits serially from upstream.
- Drives the parity LFSR (clear, shift enable, feedback gate) and the output mux (message vs parity).
- Drives the 15-bit serial-in/parallel-out collector: sync clear, hold.
- Holds the finished codeword with cw_valid until downstream acknowledges it.

Parameters:
N, 15, codeword length in bits
K, 7, message length in bits (parity length is N-K = 8)
CW, 4, counter width; must satisfy 2**CW >= max(K, N-K)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  request to begin a new codeword
bit_valid  input  1  upstream message bit valid this cycle
bit_ready  output  1  controller accepts a message bit this cycle
cw_ack  input  1  downstream has consumed the parallel codeword
enc_clr  output  1  synchronous clear to parity LFSR, active-high
enc_en  output  1  parity LFSR shift enable
enc_gate  output  1  LFSR feedback gate: 1 = message phase, 0 = parity flush
sel_par  output  1  serial output mux select: 0 = message bit, 1 = parity bit
sipo_clr  output  1  synchronous clear to collector, active-high
sipo_hold  output  1  collector hold, active-high
cw_valid  output  1  collector holds a complete codeword
busy  output  1  controller not in IDLE
bit_cnt  output  CW  bit index within the current phase

Behaviour:
- Reset (reset=0, async) → state IDLE, bit_cnt=0. Registered outputs cw_valid=0, busy=0.
- Reset values of all other outputs: enc_clr=0, enc_en=0, enc_gate=0, sel_par=0, sipo_clr=0, sipo_hold=1, bit_ready=0.
- Reset asserted mid-codeword aborts it; there is no resume.
- Control outputs are combinational from state, bit_valid, start and cw_ack. State, bit_cnt, cw_valid and busy are registered.
- IDLE:
  - sipo_hold=1, all enables 0.
  - start=1 → enc_clr=1 and sipo_clr=1 in the same cycle; next state MSG, bit_cnt←0.
- MSG:
  - bit_ready=1, enc_gate=1, sel_par=0.
  - Transfer occurs when bit_valid=1: enc_en=1, sipo_hold=0, bit_cnt++.
  - bit_valid=0 is a stall: enc_en=0, sipo_hold=1, bit_cnt unchanged. Stalls are unbounded.
  - Transfer at bit_cnt=K-1 → PAR, bit_cnt←0.
- PAR:
  - No stalls. Every cycle: enc_en=1, enc_gate=0, sel_par=1, sipo_hold=0, bit_ready=0.
  - At bit_cnt=N-K-1 → DONE, bit_cnt←0.
- DONE:
  - cw_valid=1, sipo_hold=1, enc_en=0.
  - cw_ack=1 and start=0 → IDLE.
  - cw_ack=1 and start=1 → back-to-back: enc_clr=1 and sipo_clr=1 this cycle, next state MSG.
  - start without cw_ack is ignored.
- start outside IDLE/DONE is ignored. cw_ack outside DONE is ignored.
- bit_valid outside MSG is ignored; bit_ready=0 there.
- Latency:
  - bit_ready rises 1 cycle after the start cycle.
  - cw_valid rises in the cycle after the last parity shift.
  - Minimum start-to-cw_valid = 1 + K + (N-K) = 16 cycles.
- Collector sees exactly N shifts per codeword: K message bits first, then N-K parity bits.
- busy=1 in MSG, PAR, DONE.
- bit_cnt wraps only via the explicit phase resets above and never exceeds max(K, N-K)-1.

Decomposition:
- Shared package bch_pkg:
  - constants BCH_N=15, BCH_K=7, BCH_P=8.
  - 2-bit state encoding: IDLE=00, MSG=01, PAR=10, DONE=11.
- Single module with one FSM and one phase counter; no sub-module needed.
- The collector and LFSR remain separate blocks, wired at the encoder top.

Test Plan:
1. Reset low for 3 cycles mid-PAR at bit_cnt=3 → state IDLE, cw_valid=0, busy=0 and sipo_hold=1 immediately, without waiting for clk; after release, start restarts cleanly.
2. start, then bit_valid=1 for 7 cycles with message 1011001 → enc_en high for 15 consecutive cycles, sel_par 0 for 7 then 1 for 8; cw_valid rises at cycle 16; collector holds the correct BCH(15,7) codeword.
3. Same message with bit_valid low for 2 cycles after bit 3 → bit_cnt frozen at 3, sipo_hold=1 and enc_en=0 during the stall; cw_valid at cycle 18; same codeword.
4. Hold cw_ack=0 for 10 cycles in DONE with start pulsed → cw_valid stays 1, no clears; cw_ack=1 → IDLE next cycle.
5. In DONE, assert cw_ack=1 and start=1 together → sipo_clr=enc_clr=1 that cycle, MSG next cycle, bit_ready=1, bit_cnt=0.
6. Pulse bit_valid in IDLE, PAR and DONE, and pulse cw_ack in MSG → no state, bit_cnt or output change.

Source files
------------

// File: rtl/bch_pkg.sv
// ---------------------------------------------------------------------------
// bch_pkg
//   Shared constants and the controller state encoding for the serial
//   BCH(15,7) encode path.
//   BCH_N : codeword length in bits
//   BCH_K : message length in bits
//   BCH_P : parity length in bits (BCH_N - BCH_K)
//   state_t : IDLE=00, MSG=01, PAR=10, DONE=11
// ---------------------------------------------------------------------------
package bch_pkg;

    localparam int BCH_N = 15;
    localparam int BCH_K = 7;
    localparam int BCH_P = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MSG  = 2'b01,
        ST_PAR  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/bch_enc_ctrl.sv
// ---------------------------------------------------------------------------
// bch_enc_ctrl
//   Sequencing controller for the serial BCH(15,7) encoder. Accepts K message
//   bits, then flushes N-K parity bits, then holds the collected codeword
//   until downstream acknowledges it.
//
//   Ports
//     clk        : rising-edge clock
//     reset      : asynchronous active-low reset
//     start      : begin a new codeword (honoured in IDLE, or DONE with cw_ack)
//     bit_valid  : upstream message bit valid
//     bit_ready  : controller accepts a message bit this cycle
//     cw_ack     : downstream consumed the codeword (honoured in DONE)
//     enc_clr    : sync clear to parity LFSR
//     enc_en     : parity LFSR shift enable
//     enc_gate   : LFSR feedback gate (1 = message phase, 0 = parity flush)
//     sel_par    : serial output mux select (0 = message, 1 = parity)
//     sipo_clr   : sync clear to the codeword collector
//     sipo_hold  : collector hold
//     cw_valid   : collector holds a complete codeword (registered)
//     busy       : controller not in IDLE (registered)
//     bit_cnt    : bit index within the current phase (registered)
// ---------------------------------------------------------------------------
module bch_enc_ctrl
    import bch_pkg::*;
#(
    parameter int N  = BCH_N,
    parameter int K  = BCH_K,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          bit_valid,
    output logic          bit_ready,
    input  logic          cw_ack,
    output logic          enc_clr,
    output logic          enc_en,
    output logic          enc_gate,
    output logic          sel_par,
    output logic          sipo_clr,
    output logic          sipo_hold,
    output logic          cw_valid,
    output logic          busy,
    output logic [CW-1:0] bit_cnt
);

    localparam logic [CW-1:0] LAST_MSG = CW'(K - 1);
    localparam logic [CW-1:0] LAST_PAR = CW'(N - K - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_bit_cnt;
    logic [CW-1:0] w_bit_cnt_nxt;
    logic          r_cw_valid;
    logic          r_busy;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_cw_valid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            // Derived from the next state so the flags line up with r_state.
            r_cw_valid <= (w_state_nxt == ST_DONE);
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    // NOTE: every output of this block is given a default before the case so
    // no path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        bit_ready     = 1'b0;
        enc_clr       = 1'b0;
        enc_en        = 1'b0;
        enc_gate      = 1'b0;
        sel_par       = 1'b0;
        sipo_clr      = 1'b0;
        sipo_hold     = 1'b1;

        // Outputs also decode start/bit_valid/cw_ack, so reset must mask them
        // directly rather than rely on the state register alone.
        if (reset) begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        enc_clr       = 1'b1;
                        sipo_clr      = 1'b1;
                        w_state_nxt   = ST_MSG;
                        w_bit_cnt_nxt = '0;
                    end
                end

                ST_MSG: begin
                    bit_ready = 1'b1;
                    enc_gate  = 1'b1;
                    if (bit_valid) begin
                        enc_en    = 1'b1;
                        sipo_hold = 1'b0;
                        if (r_bit_cnt == LAST_MSG) begin
                            w_state_nxt   = ST_PAR;
                            w_bit_cnt_nxt = '0;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + CW'(1);
                        end
                    end
                end

                ST_PAR: begin
                    enc_en    = 1'b1;
                    sel_par   = 1'b1;
                    sipo_hold = 1'b0;
                    if (r_bit_cnt == LAST_PAR) begin
                        w_state_nxt   = ST_DONE;
                        w_bit_cnt_nxt = '0;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + CW'(1);
                    end
                end

                ST_DONE: begin
                    if (cw_ack) begin
                        w_bit_cnt_nxt = '0;
                        if (start) begin
                            // Back-to-back: clear both datapath blocks now so
                            // the first message bit lands next cycle.
                            enc_clr     = 1'b1;
                            sipo_clr    = 1'b1;
                            w_state_nxt = ST_MSG;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end

                default: begin
                    w_state_nxt   = ST_IDLE;
                    w_bit_cnt_nxt = '0;
                end
            endcase
        end
    end

    assign cw_valid = r_cw_valid;
    assign busy     = r_busy;
    assign bit_cnt  = r_bit_cnt;

endmodule
